// File: rtl/pattern_test_sequencer.sv
// Pattern-finder test sequencer: advances a vector ROM reader, waits for the finder
// pipeline to settle on each vector, then compares its results against expectations.
module pattern_test_sequencer #(
    parameter int MXADRB  = 10,
    parameter int LATENCY = 4,
    parameter int ERRB    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        cmp_en,
    input  logic [MXADRB-1:0] rom_adr,
    input  logic              rom_done,
    input  logic [7:0]        key_hs_expect_1st,
    input  logic [7:0]        key_hs_expect_2nd,
    input  logic [3:0]        pat_expect_1st,
    input  logic [3:0]        pat_expect_2nd,
    input  logic [1:0]        state_expect,
    input  logic [7:0]        key_hs_1st,
    input  logic [7:0]        key_hs_2nd,
    input  logic [3:0]        pat_1st,
    input  logic [3:0]        pat_2nd,
    input  logic [1:0]        state_act,
    output logic              increment,
    output logic              busy,
    output logic              run_done,
    output logic              pass,
    output logic              err_pulse,
    output logic [ERRB-1:0]   err_cnt,
    output logic [MXADRB:0]   vec_cnt,
    output logic [MXADRB-1:0] first_err_adr,
    output logic [4:0]        err_flags
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int                VW        = MXADRB + 1;
    localparam logic [3:0]        WAIT_LOAD = 4'(LATENCY - 1);
    localparam logic [MXADRB-1:0] LAST_ADR  = {MXADRB{1'b1}};
    localparam logic [MXADRB:0]   FULL_VECS = {1'b1, {MXADRB{1'b0}}};
    localparam logic [MXADRB:0]   VEC_ONE   = VW'(1);
    localparam logic [ERRB-1:0]   ERR_MAX   = {ERRB{1'b1}};
    localparam logic [ERRB-1:0]   ERR_ZERO  = {ERRB{1'b0}};
    localparam logic [ERRB-1:0]   ERR_ONE   = ERRB'(1);

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              last_q, last_d;
    logic              increment_q, increment_d;
    logic              busy_q, busy_d;
    logic              run_done_q, run_done_d;
    logic              pass_q, pass_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERRB-1:0]   err_cnt_q, err_cnt_d;
    logic [MXADRB:0]   vec_cnt_q, vec_cnt_d;
    logic [MXADRB-1:0] first_err_adr_q, first_err_adr_d;
    logic [4:0]        err_flags_q, err_flags_d;

    logic [4:0]        field_miss_s;
    logic              mismatch_s;
    logic              run_start_s;
    logic              check_entry_s;

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wait_q          <= 4'd0;
            last_q          <= 1'b0;
            increment_q     <= 1'b0;
            busy_q          <= 1'b0;
            run_done_q      <= 1'b0;
            pass_q          <= 1'b0;
            err_pulse_q     <= 1'b0;
            err_cnt_q       <= ERR_ZERO;
            vec_cnt_q       <= {VW{1'b0}};
            first_err_adr_q <= {MXADRB{1'b0}};
            err_flags_q     <= 5'd0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            last_q          <= last_d;
            increment_q     <= increment_d;
            busy_q          <= busy_d;
            run_done_q      <= run_done_d;
            pass_q          <= pass_d;
            err_pulse_q     <= err_pulse_d;
            err_cnt_q       <= err_cnt_d;
            vec_cnt_q       <= vec_cnt_d;
            first_err_adr_q <= first_err_adr_d;
            err_flags_q     <= err_flags_d;
        end
    end

    // Next-state: abort outranks an unexpected rom_done, which outranks the settle timer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = rom_done ? S_DONE : S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rom_done) begin
                    state_d = S_DONE;
                end else if (wait_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign field_miss_s = cmp_en & {state_act  != state_expect,
                                    pat_2nd    != pat_expect_2nd,
                                    key_hs_2nd != key_hs_expect_2nd,
                                    pat_1st    != pat_expect_1st,
                                    key_hs_1st != key_hs_expect_1st};
    assign mismatch_s    = |field_miss_s;
    assign run_start_s   = (state_q == S_IDLE) && (state_d != S_IDLE);
    assign check_entry_s = (state_q == S_SETTLE) && (state_d == S_CHECK);

    // Datapath and output flops: the compare is captured on the edge that enters CHECK,
    // so err_pulse and increment are both visible during the CHECK clock.
    always_comb begin
        wait_d          = wait_q;
        last_d          = last_q;
        err_cnt_d       = err_cnt_q;
        vec_cnt_d       = vec_cnt_q;
        first_err_adr_d = first_err_adr_q;
        err_flags_d     = err_flags_q;
        if (run_start_s) begin
            wait_d          = WAIT_LOAD;
            last_d          = 1'b0;
            err_cnt_d       = ERR_ZERO;
            vec_cnt_d       = {VW{1'b0}};
            first_err_adr_d = {MXADRB{1'b0}};
            err_flags_d     = 5'd0;
        end else if (check_entry_s) begin
            last_d    = (rom_adr == LAST_ADR);
            vec_cnt_d = vec_cnt_q + VEC_ONE;
            if (mismatch_s) begin
                if (err_cnt_q == ERR_ZERO) begin
                    first_err_adr_d = rom_adr;
                end else begin
                    first_err_adr_d = first_err_adr_q;
                end
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                err_flags_d = err_flags_q | field_miss_s;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else if (state_q == S_SETTLE) begin
            wait_d = wait_q - 4'd1;
        end else if (state_q == S_CHECK) begin
            wait_d = WAIT_LOAD;
        end else begin
            wait_d = wait_q;
        end

        increment_d = check_entry_s;
        err_pulse_d = check_entry_s && mismatch_s;
        busy_d      = (state_d == S_SETTLE) || (state_d == S_CHECK);
        run_done_d  = (state_d == S_DONE);
        pass_d      = run_done_d && (err_cnt_d == ERR_ZERO) && (vec_cnt_d == FULL_VECS);
    end

    // An abort arriving during CHECK withholds the advance pulse in that same clock.
    assign increment     = increment_q & ~abort;
    assign busy          = busy_q;
    assign run_done      = run_done_q;
    assign pass          = pass_q;
    assign err_pulse     = err_pulse_q;
    assign err_cnt       = err_cnt_q;
    assign vec_cnt       = vec_cnt_q;
    assign first_err_adr = first_err_adr_q;
    assign err_flags     = err_flags_q;

endmodule

// File: tb/tb_pattern_test_sequencer.sv
// Bench for pattern_test_sequencer: directed scenarios with literal expectations plus
// randomized runs, all checked every cycle against a run-level behavioural model.
module tb_pattern_test_sequencer;

    localparam int MXADRB  = 2;
    localparam int LATENCY = 4;
    localparam int ERRB    = 2;
    localparam int NVEC    = 1 << MXADRB;
    localparam int ERR_MAX = (1 << ERRB) - 1;

    logic              clock;
    logic              reset, start, abort, rom_done;
    logic [4:0]        cmp_en;
    logic [MXADRB-1:0] rom_adr;
    logic [7:0]        key_hs_expect_1st, key_hs_expect_2nd, key_hs_1st, key_hs_2nd;
    logic [3:0]        pat_expect_1st, pat_expect_2nd, pat_1st, pat_2nd;
    logic [1:0]        state_expect, state_act;
    logic              increment, busy, run_done, pass, err_pulse;
    logic [ERRB-1:0]   err_cnt;
    logic [MXADRB:0]   vec_cnt;
    logic [MXADRB-1:0] first_err_adr;
    logic [4:0]        err_flags;

    pattern_test_sequencer #(.MXADRB(MXADRB), .LATENCY(LATENCY), .ERRB(ERRB)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .cmp_en(cmp_en),
        .rom_adr(rom_adr), .rom_done(rom_done),
        .key_hs_expect_1st(key_hs_expect_1st), .key_hs_expect_2nd(key_hs_expect_2nd),
        .pat_expect_1st(pat_expect_1st), .pat_expect_2nd(pat_expect_2nd),
        .state_expect(state_expect), .key_hs_1st(key_hs_1st), .key_hs_2nd(key_hs_2nd),
        .pat_1st(pat_1st), .pat_2nd(pat_2nd), .state_act(state_act),
        .increment(increment), .busy(busy), .run_done(run_done), .pass(pass),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
        .first_err_adr(first_err_adr), .err_flags(err_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    // Vector tables served by the bench acting as ROM reader and finder.
    logic [7:0] tk1 [NVEC];
    logic [7:0] tk2 [NVEC];
    logic [3:0] tp1 [NVEC];
    logic [3:0] tp2 [NVEC];
    logic [1:0] tst [NVEC];
    logic [4:0] corrupt [NVEC];

    int step_idx;
    int n_pulse;
    int inc_steps[$];

    // Run-level model: mode 0 idle, 1 running, 2 done; k counts clocks since start.
    int       m_mode, m_k, m_err, m_vec, m_first;
    logic [4:0] m_flags;
    logic     m_inc, m_pulse, m_last, m_valid;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_miss();
        logic [4:0] m;
        m = 5'd0;
        if (cmp_en[0] && key_hs_1st != key_hs_expect_1st) m[0] = 1'b1;
        if (cmp_en[1] && pat_1st    != pat_expect_1st)    m[1] = 1'b1;
        if (cmp_en[2] && key_hs_2nd != key_hs_expect_2nd) m[2] = 1'b1;
        if (cmp_en[3] && pat_2nd    != pat_expect_2nd)    m[3] = 1'b1;
        if (cmp_en[4] && state_act  != state_expect)      m[4] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        m_err = 0; m_vec = 0; m_first = 0; m_flags = 5'd0; m_last = 1'b0;
    endtask

    // Predicts what the outputs hold after the coming rising edge, from inputs now stable.
    task automatic model_advance();
        logic [4:0] miss;
        m_inc = 1'b0;
        m_pulse = 1'b0;
        if (reset) begin
            m_mode = 0; m_k = 0; model_clear(); m_valid = 1'b1;
        end else if (m_mode == 0) begin
            if (start && !abort) begin
                model_clear();
                m_k = 0;
                m_mode = rom_done ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            m_k++;
            if (abort) m_mode = 0;
            else if (m_k % (LATENCY + 1) == 0) begin
                if (m_last) m_mode = 2;
            end else if (rom_done) m_mode = 2;
            else if (m_k % (LATENCY + 1) == LATENCY) begin
                m_inc = 1'b1;
                m_vec++;
                m_last = (int'(rom_adr) == NVEC - 1);
                miss = model_miss();
                if (miss != 5'd0) begin
                    m_pulse = 1'b1;
                    if (m_err == 0) m_first = int'(rom_adr);
                    if (m_err < ERR_MAX) m_err++;
                    m_flags = m_flags | miss;
                end
            end
        end
    endtask

    // Per-cycle compare of every output against the model, away from the active edge.
    initial begin
        m_valid = 1'b0;
        m_mode = 0; m_k = 0; m_inc = 1'b0; m_pulse = 1'b0;
        model_clear();
        forever begin
            @(negedge clock);
            if (m_valid) begin
                chk("increment",     int'(increment),     int'(m_inc && !abort));
                chk("busy",          int'(busy),          int'(m_mode == 1));
                chk("run_done",      int'(run_done),      int'(m_mode == 2));
                chk("pass",          int'(pass),          int'(m_mode == 2 && m_err == 0 && m_vec == NVEC));
                chk("err_pulse",     int'(err_pulse),     int'(m_pulse));
                chk("err_cnt",       int'(err_cnt),       m_err);
                chk("vec_cnt",       int'(vec_cnt),       m_vec);
                chk("first_err_adr", int'(first_err_adr), m_first);
                chk("err_flags",     int'(err_flags),     int'(m_flags));
            end
            model_advance();
        end
    end

    task automatic drive_fields();
        logic [4:0] c;
        c = corrupt[rom_adr];
        key_hs_expect_1st = tk1[rom_adr];
        key_hs_expect_2nd = tk2[rom_adr];
        pat_expect_1st    = tp1[rom_adr];
        pat_expect_2nd    = tp2[rom_adr];
        state_expect      = tst[rom_adr];
        key_hs_1st = tk1[rom_adr] ^ (c[0] ? 8'h5A : 8'h00);
        pat_1st    = tp1[rom_adr] ^ (c[1] ? 4'h9  : 4'h0);
        key_hs_2nd = tk2[rom_adr] ^ (c[2] ? 8'hA5 : 8'h00);
        pat_2nd    = tp2[rom_adr] ^ (c[3] ? 4'h6  : 4'h0);
        state_act  = tst[rom_adr] ^ (c[4] ? 2'h1  : 2'h0);
    endtask

    // One clock: observe outputs at the falling edge, then act as the reader after the rise.
    task automatic step();
        logic inc_seen, rst_seen;
        @(negedge clock);
        step_idx++;
        inc_seen = increment;
        rst_seen = reset;
        if (inc_seen) inc_steps.push_back(step_idx);
        if (err_pulse) n_pulse++;
        @(posedge clock);
        #1;
        if (rst_seen) rom_adr = '0;
        else if (inc_seen) rom_adr = rom_adr + 1'b1;
        drive_fields();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic new_tables(input logic [4:0] c_all, input int corrupt_pct);
        for (int a = 0; a < NVEC; a++) begin
            tk1[a] = 8'($urandom); tk2[a] = 8'($urandom);
            tp1[a] = 4'($urandom); tp2[a] = 4'($urandom); tst[a] = 2'($urandom);
            corrupt[a] = c_all;
            if (corrupt_pct > 0)
                for (int f = 0; f < 5; f++)
                    corrupt[a][f] = ($urandom_range(0, 99) < corrupt_pct);
        end
        drive_fields();
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0; abort = 1'b0; rom_done = 1'b0;
        steps(2);
        reset = 1'b0;
        step_idx = 0; n_pulse = 0; inc_steps.delete();
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; rom_done = 1'b0;
        cmp_en = 5'h1F; rom_adr = '0;
        new_tables(5'd0, 0);

        // Clean run: four advances spaced by LATENCY+1, then pass.
        reset_dut();
        chk("reset_busy", int'(busy), 0);
        chk("reset_vec_cnt", int'(vec_cnt), 0);
        launch();
        steps(24);
        chk("clean_inc_count", inc_steps.size(), 4);
        if (inc_steps.size() == 4) begin
            chk("clean_first_inc_step", inc_steps[0], 6);
            for (int i = 1; i < 4; i++) chk("clean_inc_gap", inc_steps[i] - inc_steps[i-1], 5);
        end
        chk("clean_pass", int'(pass), 1);
        chk("clean_vec_cnt", int'(vec_cnt), 4);
        chk("clean_err_cnt", int'(err_cnt), 0);
        start = 1'b1;
        steps(3);
        start = 1'b0;
        chk("done_hold_run_done", int'(run_done), 1);
        chk("done_hold_vec_cnt", int'(vec_cnt), 4);

        // key_hs_1st wrong at address 2 only.
        new_tables(5'd0, 0);
        corrupt[2] = 5'h01;
        reset_dut();
        launch();
        steps(24);
        chk("key1_err_pulses", n_pulse, 1);
        chk("key1_err_cnt", int'(err_cnt), 1);
        chk("key1_first_adr", int'(first_err_adr), 2);
        chk("key1_flags", int'(err_flags), 1);
        chk("key1_pass", int'(pass), 0);

        // Mismatch only in a disabled state field.
        cmp_en = 5'h0F;
        new_tables(5'h10, 0);
        reset_dut();
        launch();
        steps(24);
        chk("masked_err_cnt", int'(err_cnt), 0);
        chk("masked_pass", int'(pass), 1);
        cmp_en = 5'h1F;

        // Abort during the second SETTLE.
        new_tables(5'd0, 0);
        reset_dut();
        launch();
        steps(5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        steps(12);
        chk("abort_inc_count", inc_steps.size(), 1);
        chk("abort_vec_cnt", int'(vec_cnt), 1);
        chk("abort_run_done", int'(run_done), 0);

        // Reset during the first CHECK.
        reset_dut();
        launch();
        steps(4);
        chk("check_inc_high", int'(increment), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_inc", int'(increment), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vec_cnt", int'(vec_cnt), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);

        // Saturating error counter with every vector wrong.
        new_tables(5'h1F, 0);
        reset_dut();
        launch();
        steps(24);
        chk("sat_err_cnt", int'(err_cnt), 3);
        chk("sat_pulses", n_pulse, 4);
        chk("sat_flags", int'(err_flags), 31);

        // start with rom_done already set; start with abort.
        new_tables(5'd0, 0);
        reset_dut();
        rom_done = 1'b1;
        launch();
        rom_done = 1'b0;
        chk("romdone_idle_run_done", int'(run_done), 1);
        chk("romdone_idle_pass", int'(pass), 0);
        reset_dut();
        abort = 1'b1;
        launch();
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);

        // rom_done rising in SETTLE.
        reset_dut();
        launch();
        steps(2);
        rom_done = 1'b1;
        step();
        rom_done = 1'b0;
        chk("romdone_settle_run_done", int'(run_done), 1);
        chk("romdone_settle_pass", int'(pass), 0);

        // Randomized runs: the per-cycle model is the reference.
        for (int r = 0; r < 60; r++) begin
            cmp_en = 5'($urandom);
            new_tables(5'd0, (r % 3 == 0) ? 0 : 15);
            reset_dut();
            rom_done = ($urandom_range(0, 9) == 0);
            abort    = ($urandom_range(0, 9) == 0);
            launch();
            rom_done = 1'b0; abort = 1'b0;
            for (int s = 0; s < 26; s++) begin
                abort    = ($urandom_range(0, 39) == 0);
                rom_done = ($urandom_range(0, 29) == 0);
                reset    = ($urandom_range(0, 79) == 0);
                start    = ($urandom_range(0, 19) == 0);
                step();
            end
            abort = 1'b0; rom_done = 1'b0; reset = 1'b0; start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
